// File: rtl/convol_pkg.sv
// Shared types and constants for the convol_mla convolution engine.
// Optional saturation of the output is selected with the CONVOL_SAT_EN macro (see convol_mla).
package convol_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned ProdWidth = 2 * DataWidth;

    typedef enum logic {
        StRun,
        StDone
    } state_t;

    // Wide enough for min(m, n) full-scale products summed together.
    function automatic int unsigned acc_width(input int unsigned m, input int unsigned n);
        int unsigned terms;
        terms = (m < n) ? m : n;
        return ProdWidth + $clog2(terms + 1);
    endfunction

endpackage

// File: rtl/convol_mac.sv
// Combinational multiply-accumulate producing the full-width y[k] from the stored samples plus
// the samples presented at edge k.
module convol_mac
    import convol_pkg::*;
#(
    parameter int unsigned m        = 6,
    parameter int unsigned n        = 5,
    parameter int unsigned KWidth   = 4,
    parameter int unsigned AccWidth = acc_width(m, n)
) (
    input  logic [DataWidth-1:0] a_vec [m],
    input  logic [DataWidth-1:0] b_vec [n],
    input  logic [KWidth-1:0]    k,
    input  logic [DataWidth-1:0] a_in,
    input  logic [DataWidth-1:0] b_in,
    output logic [AccWidth-1:0]  y
);

    logic [DataWidth-1:0] a_eff [m];
    logic [DataWidth-1:0] b_eff [n];

    // Effective A: stored below k, live input at k, zero beyond (not yet seen).
    always_comb begin
        for (int i = 0; i < int'(m); i++) begin
            a_eff[i] = '0;
            if (KWidth'(i) < k) begin
                a_eff[i] = a_vec[i];
            end else if (KWidth'(i) == k) begin
                a_eff[i] = a_in;
            end
        end
    end

    // Effective B, same rule as A.
    always_comb begin
        for (int j = 0; j < int'(n); j++) begin
            b_eff[j] = '0;
            if (KWidth'(j) < k) begin
                b_eff[j] = b_vec[j];
            end else if (KWidth'(j) == k) begin
                b_eff[j] = b_in;
            end
        end
    end

    // Sum every A[i]*B[j] pair on the anti-diagonal i + j == k.
    always_comb begin
        logic [ProdWidth-1:0] prod;
        logic [AccWidth-1:0]  acc;
        acc  = '0;
        prod = '0;
        for (int i = 0; i < int'(m); i++) begin
            for (int j = 0; j < int'(n); j++) begin
                if (KWidth'(i + j) == k) begin
                    prod = ProdWidth'(a_eff[i]) * ProdWidth'(b_eff[j]);
                    acc  = acc + AccWidth'(prod);
                end
            end
        end
        y = acc;
    end

endmodule

// File: rtl/convol_mla.sv
// Streaming 1-D full linear convolution: captures m samples of A and n samples of B after reset
// and emits the m+n-1 outputs serially, then holds out=0 until the next reset.
// Define CONVOL_SAT_EN to saturate out at 255 instead of wrapping modulo 256.
module convol_mla
    import convol_pkg::*;
#(
    parameter int unsigned m = 6,
    parameter int unsigned n = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    output logic [DataWidth-1:0] out
);

    localparam int unsigned        KWidth   = $clog2(m + n);
    localparam int unsigned        AccWidth = acc_width(m, n);
    localparam logic [KWidth-1:0]  KLast    = KWidth'(m + n - 2);

    state_t               state_q, state_d;
    logic [KWidth-1:0]    k_q, k_d;
    logic [DataWidth-1:0] out_q, out_d;
    logic [DataWidth-1:0] a_q [m];
    logic [DataWidth-1:0] b_q [n];
    logic [AccWidth-1:0]  y;

    convol_mac #(
        .m        (m),
        .n        (n),
        .KWidth   (KWidth),
        .AccWidth (AccWidth)
    ) u_mac (
        .a_vec (a_q),
        .b_vec (b_q),
        .k     (k_q),
        .a_in  (A),
        .b_in  (B),
        .y     (y)
    );

    // Sample capture: slot k takes the live input at edge k; later inputs are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(m); i++) a_q[i] <= '0;
            for (int j = 0; j < int'(n); j++) b_q[j] <= '0;
        end else if (state_q == StRun) begin
            for (int i = 0; i < int'(m); i++) begin
                if (k_q == KWidth'(i)) a_q[i] <= A;
            end
            for (int j = 0; j < int'(n); j++) begin
                if (k_q == KWidth'(j)) b_q[j] <= B;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            k_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; out is forced to zero once the last output has been registered.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        out_d   = '0;
        unique case (state_q)
            StRun: begin
`ifdef CONVOL_SAT_EN
                out_d = (y > AccWidth'((1 << DataWidth) - 1)) ? '1 : DataWidth'(y);
`else
                out_d = DataWidth'(y);
`endif
                if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + KWidth'(1);
                end
            end
            StDone: begin
                out_d = '0;
            end
        endcase
    end

    assign out = out_q;

endmodule

// File: tb/tb_convol_mla.sv
// Directed self-checking bench for convol_mla: nominal 6x5 sequence, held reset, mid-run reset,
// ignored extra samples, 2x2 overflow and the 1x1 degenerate case.
module tb_convol_mla;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
    logic [7:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0, a3 = '0, b3 = '0;
    logic [7:0] out1, out2, out3;

    int checks = 0;
    int errors = 0;

    logic [7:0] av [6]  = '{8'd1, 8'd4, 8'd3, 8'd4, 8'd3, 8'd1};
    logic [7:0] bv [5]  = '{8'd3, 8'd2, 8'd3, 8'd2, 8'd3};
    logic [7:0] ey [10] = '{8'd3, 8'd14, 8'd20, 8'd32, 8'd37, 8'd39, 8'd28, 8'd21, 8'd11, 8'd3};
`ifdef CONVOL_SAT_EN
    logic [7:0] ey2 [3] = '{8'd255, 8'd255, 8'd255};
`else
    logic [7:0] ey2 [3] = '{8'd1, 8'd2, 8'd1};
`endif

    always #5 clk = ~clk;

    convol_mla #(.m(6), .n(5)) u_dut1 (.clk(clk), .rst(rst1), .A(a1), .B(b1), .out(out1));
    convol_mla #(.m(2), .n(2)) u_dut2 (.clk(clk), .rst(rst2), .A(a2), .B(b2), .out(out2));
    convol_mla #(.m(1), .n(1)) u_dut3 (.clk(clk), .rst(rst3), .A(a3), .B(b3), .out(out3));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: releases reset and streams the 6x5 sequence, checking each output.
    task automatic run1(input string tag, input int steps, input logic [7:0] a_extra,
                        input logic b_hold);
        rst1 = 1'b0;
        for (int t = 0; t < steps; t++) begin
            a1 = (t < 6) ? av[t] : a_extra;
            b1 = (t < 5) ? bv[t] : (b_hold ? bv[4] : 8'd9);
            @(negedge clk);
            check($sformatf("%s_y%0d", tag, t), out1, (t < 10) ? ey[t] : 8'd0);
        end
    endtask

    initial begin
        // Reset held with random inputs: all outputs stay zero.
        for (int c = 0; c < 10; c++) begin
            a1 = 8'($urandom); b1 = 8'($urandom);
            a2 = 8'($urandom); b2 = 8'($urandom);
            a3 = 8'($urandom); b3 = 8'($urandom);
            @(negedge clk);
            check($sformatf("rst1_c%0d", c), out1, 8'd0);
            check($sformatf("rst2_c%0d", c), out2, 8'd0);
            check($sformatf("rst3_c%0d", c), out3, 8'd0);
        end

        // Nominal run, B held at its last value, A driven 0 past its length; then DONE zeros.
        run1("nom", 13, 8'd0, 1'b1);

        // Fresh run aborted after three outputs.
        rst1 = 1'b1;
        @(negedge clk);
        run1("abort", 3, 8'd0, 1'b1);
        rst1 = 1'b1;
        a1 = 8'hAA; b1 = 8'h55;
        @(negedge clk);
        check("midrst_clear", out1, 8'd0);
        @(negedge clk);
        check("midrst_hold", out1, 8'd0);

        // Replay with 9s beyond both lengths: identical output, no residue.
        run1("replay9", 13, 8'd9, 1'b0);

        // 2x2 overflow case.
        rst2 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            a2 = 8'd255; b2 = 8'd255;
            @(negedge clk);
            check($sformatf("ovf_y%0d", t), out2, (t < 3) ? ey2[t] : 8'd0);
        end

        // 1x1 degenerate case.
        rst3 = 1'b0;
        a3 = 8'd7; b3 = 8'd6;
        @(negedge clk);
        check("one_y0", out3, 8'd42);
        a3 = 8'd99; b3 = 8'd99;
        @(negedge clk);
        check("one_done", out3, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/convol_mla.md
# convol_mla

Streaming 1-D linear convolution engine for the MLA datapath. After reset it captures an m-sample sequence on A and an n-sample sequence on B, one sample per clock. It emits the m+n-1 full-convolution outputs y[k] = Σ A[i]·B[k-i] serially on out, one per clock, then idles until the next reset.

## Interface
- m, default 6, length of sequence A (≥1)
- n, default 5, length of sequence B (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, reset is synchronous and active-high
- A  input  8  unsigned sample of sequence A
- B  input  8  unsigned sample of sequence B
- out  output  8  unsigned convolution result, one y[k] per cycle

## Operation
- Sample counter k starts at 0 on the first rising edge where rst is sampled low, and increments by 1 per edge.
- At edge k (k<m) A is captured as A[k]. At edge k (k<n) B is captured as B[k].
- A is ignored for k≥m and B is ignored for k≥n. Missing terms are treated as 0.
- y[k] = Σ over i=max(0,k-n+1)..min(k,m-1) of A[i]·B[k-i], for k = 0..m+n-2.
  - Input-to-product width: 8×8 gives 16-bit products.
  - Accumulator width: 16+$clog2(min(m,n)+1) bits, so the sum never overflows internally.
- out carries the low 8 bits of y[k] (modulo 256) unless the saturation option is enabled.
- The y[k] computation uses the sample presented at edge k together with all previously stored samples.
- State machine has two states:
  - RUN: active while k ≤ m+n-2.
  - DONE: entered after y[m+n-2] is registered. Holds until rst; out=0; inputs are ignored.
- Unsigned arithmetic only.

## Timing
- Reset: out=0, k=0, all stored samples =0, state=RUN (waiting for the first non-reset edge).
- Latency: y[k] is registered on edge k, so it is visible on out during the cycle after edge k.
- Throughput: one output per clock, with no gaps.
- Total: m+n-1 valid output cycles. The cycle after the last valid output shows out=0 (DONE).
- Reset mid-operation: on the next edge everything clears and a new sequence restarts at k=0. No partial results are retained.
- No handshake. The driver must present one sample per clock, starting at the first clock after rst falls.
  - Drive inputs away from the rising edge, e.g. on the falling edge.
- m≠n is supported: the shorter sequence is zero-padded implicitly.

## Configuration
- CONVOL_SAT_EN
  - Defined: out = min(y[k], 255), i.e. saturating.
  - Undefined: out = y[k][7:0], i.e. wrapping.
- All other behaviour is identical in both modes.

## Structure
- Package convol_pkg holds:
  - the state enum (RUN, DONE)
  - the data width constant (8)
  - a function computing the accumulator width from m and n
- Sub-module convol_mac is a combinational dot-product / multiply-accumulate. It takes the stored A and B vectors, the current index k and the current inputs, and returns the full-width y[k].
- The top module holds the sample registers, the counter, the FSM and the output register/saturation.

## Test plan
- m=6, n=5; rst high for 10 cycles, then A = 1,4,3,4,3,1 and B = 3,2,3,2,3 (B held afterwards) -> out = 3,14,20,32,37,39,28,21,11,3 on consecutive cycles, then 0.
- Reset held continuously with random A/B -> out stays 0.
- Overflow: m=n=2, A = 255,255, B = 255,255.
  - Without CONVOL_SAT_EN -> out = 1, 2, 1 (65025 mod 256 = 1; 130050 mod 256 = 2).
  - With CONVOL_SAT_EN -> out = 255, 255, 255.
- Mid-run reset: assert rst after 3 outputs of the first scenario, then replay the same stimulus -> the full 3,14,20,…,3 sequence again, with no residue from the aborted run.
- Extra inputs: in the first scenario, drive A=9 and B=9 beyond their lengths -> outputs unchanged (9s ignored).
- Degenerate m=1, n=1: A=7, B=6 -> a single output 42, then 0.
